// File: rtl/accumulate_unit.sv
// Streaming signed packet accumulator fed by an internal 8-bit block-bypass adder.
// Results are presented on a valid/ready port with sticky carry/overflow flags and a beat count.

module accumulate_unit_bypass_adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         of
);
   localparam int NB = N / 8;

   logic [N-1:0] p;
   logic [N-1:0] g;
   logic         carry;
   logic         blk_cin;

   assign p = a ^ b;
   assign g = a & b;

   // Ripple inside each 8-bit block; a fully-propagating block forwards its carry-in directly.
   always_comb begin
      s       = '0;
      carry   = cin;
      blk_cin = cin;
      for (int blk = 0; blk < NB; blk++) begin
         blk_cin = carry;
         for (int i = 0; i < 8; i++) begin
            s[blk*8+i] = p[blk*8+i] ^ carry;
            carry      = g[blk*8+i] | (p[blk*8+i] & carry);
         end
         if (&p[blk*8 +: 8]) begin
            carry = blk_cin;
         end
      end
      cout = carry;
   end

   // Carry into the sign bit is recovered from the sum bit; overflow is carry-in xor carry-out of the MSB.
   assign of = (s[N-1] ^ p[N-1]) ^ cout;

endmodule

module accumulate_unit #(
   parameter int N     = 32,
   parameter int CNT_W = 8,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sum,
   output logic             out_cout,
   output logic             out_of,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic {ACC, HOLD} state_t;

   state_t                  state_q,     state_d;
   logic signed [N-1:0]     acc_q,       acc_d;
   logic                    cout_s_q,    cout_s_d;
   logic                    of_s_q,      of_s_d;
   logic [CNT_W-1:0]        cnt_q,       cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [N-1:0]     out_sum_q,   out_sum_d;
   logic                    out_cout_q,  out_cout_d;
   logic                    out_of_q,    out_of_d;
   logic [CNT_W-1:0]        out_count_q, out_count_d;

   logic [N-1:0]            add_s;
   logic                    add_cout;
   logic                    add_of;
   logic                    accept;
   logic signed [N-1:0]     acc_next;
   logic                    cout_next;
   logic                    of_next;
   logic [CNT_W-1:0]        cnt_next;

   function automatic logic signed [N-1:0] sat_acc(
      input logic signed [N-1:0] sum,
      input logic                ovf,
      input logic                acc_msb
   );
      logic signed [N-1:0] max_v;
      logic signed [N-1:0] min_v;
      max_v = {1'b0, {(N-1){1'b1}}};
      min_v = {1'b1, {(N-1){1'b0}}};
      if (SAT && ovf) begin
         return acc_msb ? min_v : max_v;
      end
      return sum;
   endfunction

   function automatic logic [CNT_W-1:0] inc_count(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   accumulate_unit_bypass_adder #(.N(N)) u_adder (
      .a    (acc_q),
      .b    (in_data),
      .cin  (1'b0),
      .s    (add_s),
      .cout (add_cout),
      .of   (add_of)
   );

   assign in_ready  = (state_q == ACC);
   assign accept    = in_valid & in_ready;
   assign acc_next  = sat_acc($signed(add_s), add_of, acc_q[N-1]);
   assign cout_next = cout_s_q | add_cout;
   assign of_next   = of_s_q | add_of;
   assign cnt_next  = inc_count(cnt_q);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cout_s_d    = cout_s_q;
      of_s_d      = of_s_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      out_of_d    = out_of_q;
      out_count_d = out_count_q;

      if (clr) begin
         // Abort wins over any beat or handshake in the same cycle.
         state_d     = ACC;
         acc_d       = '0;
         cout_s_d    = 1'b0;
         of_s_d      = 1'b0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         out_sum_d   = '0;
         out_cout_d  = 1'b0;
         out_of_d    = 1'b0;
         out_count_d = '0;
      end else begin
         case (state_q)
            ACC: begin
               if (accept) begin
                  acc_d    = acc_next;
                  cout_s_d = cout_next;
                  of_s_d   = of_next;
                  cnt_d    = cnt_next;
                  if (in_last) begin
                     out_valid_d = 1'b1;
                     out_sum_d   = acc_next;
                     out_cout_d  = cout_next;
                     out_of_d    = of_next;
                     out_count_d = cnt_next;
                     state_d     = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d     = ACC;
                  acc_d       = '0;
                  cout_s_d    = 1'b0;
                  of_s_d      = 1'b0;
                  cnt_d       = '0;
                  out_valid_d = 1'b0;
                  out_sum_d   = '0;
                  out_cout_d  = 1'b0;
                  out_of_d    = 1'b0;
                  out_count_d = '0;
               end
            end
            default: state_d = ACC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACC;
         acc_q       <= '0;
         cout_s_q    <= 1'b0;
         of_s_q      <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_of_q    <= 1'b0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cout_s_q    <= cout_s_d;
         of_s_q      <= of_s_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_of_q    <= out_of_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cout  = out_cout_q;
   assign out_of    = out_of_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_accumulate_unit.sv
// Directed bench for accumulate_unit: wrap, saturating and narrow-counter variants share one stimulus.

module tb_accumulate_unit;

   logic        clk = 1'b0;
   logic        rst, clr, in_valid, in_last, out_ready;
   logic [31:0] in_data;

   logic        w_in_ready, w_out_valid, w_out_cout, w_out_of;
   logic [31:0] w_out_sum;
   logic [7:0]  w_out_count;

   logic        s_in_ready, s_out_valid, s_out_cout, s_out_of;
   logic [31:0] s_out_sum;
   logic [7:0]  s_out_count;

   logic        c_in_ready, c_out_valid, c_out_cout, c_out_of;
   logic [31:0] c_out_sum;
   logic [1:0]  c_out_count;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   accumulate_unit #(.N(32), .CNT_W(8), .SAT(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(w_out_valid), .out_ready(out_ready),
      .out_sum(w_out_sum), .out_cout(w_out_cout), .out_of(w_out_of), .out_count(w_out_count));

   accumulate_unit #(.N(32), .CNT_W(8), .SAT(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_sum(s_out_sum), .out_cout(s_out_cout), .out_of(s_out_of), .out_count(s_out_count));

   accumulate_unit #(.N(32), .CNT_W(2), .SAT(1'b0)) dut_cnt2 (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_sum(c_out_sum), .out_cout(c_out_cout), .out_of(c_out_of), .out_count(c_out_count));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
      step();
      step();
      check("rst_in_ready",  {31'd0, w_in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, w_out_valid}, 32'd0);
      check("rst_out_sum",   w_out_sum, 32'd0);
      check("rst_out_flags", {30'd0, w_out_cout, w_out_of}, 32'd0);
      check("rst_out_count", {24'd0, w_out_count}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;

      // Packet 5, 7, -3
      send(32'd5, 1'b0);
      send(32'd7, 1'b0);
      check("p1_no_early_valid", {31'd0, w_out_valid}, 32'd0);
      send(32'hFFFF_FFFD, 1'b1);
      check("p1_out_valid", {31'd0, w_out_valid}, 32'd1);
      check("p1_in_ready_low", {31'd0, w_in_ready}, 32'd0);
      check("p1_sum", w_out_sum, 32'd9);
      check("p1_count", {24'd0, w_out_count}, 32'd3);
      check("p1_of", {31'd0, w_out_of}, 32'd0);
      step();
      check("p1_valid_drop", {31'd0, w_out_valid}, 32'd0);
      check("p1_in_ready_back", {31'd0, w_in_ready}, 32'd1);
      check("p1_sum_cleared", w_out_sum, 32'd0);

      // Signed overflow: wrap vs saturate
      send(32'h7FFF_FFFF, 1'b0);
      send(32'd1, 1'b1);
      check("ovf_wrap_sum", w_out_sum, 32'h8000_0000);
      check("ovf_wrap_of", {31'd0, w_out_of}, 32'd1);
      check("ovf_wrap_cout", {31'd0, w_out_cout}, 32'd0);
      check("ovf_sat_sum", s_out_sum, 32'h7FFF_FFFF);
      check("ovf_sat_of", {31'd0, s_out_of}, 32'd1);
      step();

      // Negative saturation: 0x80000000 + 0xFFFFFFFF
      send(32'h8000_0000, 1'b0);
      send(32'hFFFF_FFFF, 1'b1);
      check("novf_wrap_sum", w_out_sum, 32'h7FFF_FFFF);
      check("novf_sat_sum", s_out_sum, 32'h8000_0000);
      check("novf_flags", {30'd0, w_out_cout, w_out_of}, 32'd3);
      step();

      // Carry without overflow
      send(32'hFFFF_FFFF, 1'b0);
      send(32'd1, 1'b1);
      check("cy_sum", w_out_sum, 32'd0);
      check("cy_cout", {31'd0, w_out_cout}, 32'd1);
      check("cy_of", {31'd0, w_out_of}, 32'd0);
      step();

      // Backpressure
      out_ready = 1'b0;
      send(32'd4, 1'b0);
      send(32'd6, 1'b1);
      in_data = 32'd100; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("bp_valid_held", {31'd0, w_out_valid}, 32'd1);
         check("bp_sum_held", w_out_sum, 32'd10);
         check("bp_count_held", {24'd0, w_out_count}, 32'd2);
         check("bp_in_ready_low", {31'd0, w_in_ready}, 32'd0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_release_valid", {31'd0, w_out_valid}, 32'd0);
      check("bp_release_ready", {31'd0, w_in_ready}, 32'd1);
      send(32'd2, 1'b1);
      check("bp_next_sum", w_out_sum, 32'd2);
      check("bp_next_count", {24'd0, w_out_count}, 32'd1);
      step();

      // Mid-packet clr, with a beat presented in the clr cycle that must be dropped
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      clr = 1'b1;
      send(32'd50, 1'b1);
      clr = 1'b0;
      check("clr_no_valid", {31'd0, w_out_valid}, 32'd0);
      check("clr_in_ready", {31'd0, w_in_ready}, 32'd1);
      send(32'd3, 1'b1);
      check("clr_sum", w_out_sum, 32'd3);
      check("clr_count", {24'd0, w_out_count}, 32'd1);
      step();

      // clr while holding a result
      out_ready = 1'b0;
      send(32'd8, 1'b1);
      check("hclr_valid_before", {31'd0, w_out_valid}, 32'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("hclr_valid", {31'd0, w_out_valid}, 32'd0);
      check("hclr_sum", w_out_sum, 32'd0);
      check("hclr_in_ready", {31'd0, w_in_ready}, 32'd1);
      out_ready = 1'b1;

      // Mid-packet rst
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      rst = 1'b1;
      step();
      check("rst_mid_valid", {31'd0, w_out_valid}, 32'd0);
      check("rst_mid_sum", w_out_sum, 32'd0);
      check("rst_mid_count", {24'd0, w_out_count}, 32'd0);
      check("rst_mid_flags", {30'd0, w_out_cout, w_out_of}, 32'd0);
      rst = 1'b0;
      send(32'd3, 1'b1);
      check("rst_sum", w_out_sum, 32'd3);
      check("rst_count", {24'd0, w_out_count}, 32'd1);
      step();

      // Counter saturation on the 2-bit counter
      for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
      send(32'd1, 1'b1);
      check("cnt2_sum", c_out_sum, 32'd5);
      check("cnt2_count", {30'd0, c_out_count}, 32'd3);
      check("cnt8_count", {24'd0, w_out_count}, 32'd5);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/accumulate_unit.md
# accumulate_unit

Streaming signed accumulator sitting directly downstream of the team's combinational N-bit block-bypass adder. It consumes the adder's S/Cout/OF each cycle, registers them into a running sum, and closes a packet on a last-flagged beat. It then presents the packet total, the sticky carry/overflow flags and a beat count on a valid/ready output port. The adder instance is internal: its A is the accumulator register, its B is the incoming data, and its Cin is tied 0.

## Interface
- N, 32, datapath width; must be a multiple of 8 (adder block size)
- CNT_W, 8, beat counter width
- SAT, 0, 1 = saturate accumulator on signed overflow; 0 = wrap
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous packet abort/clear
- in_valid  in  1  input beat valid
- in_ready  out  1  accumulator can accept a beat
- in_data  in  N  signed two's-complement operand
- in_last  in  1  beat closes the packet
- out_valid  out  1  packet result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  N  packet total
- out_cout  out  1  sticky OR of adder Cout over the packet
- out_of  out  1  sticky OR of adder OF over the packet
- out_count  out  CNT_W  beats accepted in packet, saturating at 2^CNT_W-1

## Operation
- States: ACC (accepting), HOLD (result presented). Reset state is ACC.
- in_ready = (state == ACC), combinational from the state register only, with no dependence on in_valid.
- ACC, beat accepted (in_valid & in_ready):
  - acc <= S, or the saturated value (see below).
  - cout_s |= Cout; of_s |= OF.
  - count <= count+1, holding at all-ones.
- ACC, accepted beat with in_last=1:
  - Register the final acc/flags/count (including this beat) into out_*.
  - out_valid <= 1; go to HOLD.
- HOLD:
  - No beats are accepted.
  - out_* are held stable while out_valid=1 & out_ready=0.
  - On out_ready: out_valid <= 0, acc/cout_s/of_s/count <= 0, go to ACC.
- Saturation (SAT=1 and OF=1 on an accepted beat):
  - acc <= 0x7FF…F if acc[N-1]=0, else 0x800…0.
  - of_s is still set.
  - With SAT=0, acc takes S unchanged (wrap).
- clr:
  - In ACC: zero acc/flags/count; any beat presented that cycle is dropped.
  - In HOLD: drop out_valid and the result, go to ACC.
  - clr has priority over every action except rst.
- rst: all state and outputs are cleared at the next edge, including mid-packet; a partial packet is discarded.
- Single-beat packet (in_last on first beat): out_sum = in_data under SAT=0, out_count=1.

## Timing
- Reset values:
  - in_ready=1 (state ACC).
  - out_valid=0, out_sum=0, out_cout=0, out_of=0, out_count=0.
- Throughput: 1 beat/cycle in ACC.
- Latency: out_valid rises on the edge that accepts the last beat, so the result is visible in the cycle after acceptance.
- Packet turnaround:
  - in_ready is 0 for every cycle in HOLD, minimum 1 cycle.
  - in_ready returns to 1 in the cycle after the out handshake.
  - There is no same-cycle out-accept/in-accept overlap.
- Adder path:
  - acc register → adder → acc register is a single-cycle combinational path.
  - The adder's OF/Cout are sampled only on accept edges.
- out_* change only on the last-beat edge, on the out handshake edge (cleared), or on clr/rst.

## Test plan
- Reset then packet 5, 7, -3 (last) with out_ready=1 → out_valid 1 cycle after the 3rd accept; out_sum=9, out_count=3, out_of=0; in_ready back to 1 the next cycle.
- N=32, SAT=0: 0x7FFFFFFF, 1 (last) → out_sum=0x80000000, out_of=1, out_cout=0; with SAT=1 the same stimulus gives out_sum=0x7FFFFFFF, out_of=1.
- Carry without overflow: 0xFFFFFFFF, 1 (last) → out_sum=0, out_cout=1, out_of=0.
- Backpressure: packet done with out_ready=0 for 4 cycles → out_* stable, in_ready=0, in_valid beats ignored; out_ready=1 → next packet 2 (last) gives out_sum=2.
- Mid-packet clr after beats 10, 20; then 3 (last) → out_sum=3, out_count=1. Repeat with rst instead of clr: same result, all outputs 0 during reset.
- CNT_W=2: 5 beats of 1, last on 5th → out_sum=5, out_count=3 (saturated).
